bus_target: RTL and testbench
=============================

# bus_target

Memory-side responder for the CPU's word-addressed bus (`addr[29:0]`, `rdata`, `wdata`, `re`, `we`). It answers every CPU access in fixed time with no wait states. The lower half of the address space is on-chip RAM with a one-cycle registered read; the upper half is a small I/O page. The I/O page holds a transmit byte FIFO that drains over a valid/ready stream, a status word, and a free-running cycle counter.

## Interface
- `RAM_WORDS`, 1024: RAM depth in 32-bit words; power of two, ≤ 2^29.
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, ≥ 2.
- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all registers except RAM contents.
- `addr` in 30: word address from CPU.
- `wdata` in 32: write data.
- `re` in 1: read strobe.
- `we` in 1: write strobe.
- `rdata` out 32: registered read data.
- `tx_data` out 8: FIFO head byte.
- `tx_valid` out 1: FIFO non-empty.
- `tx_ready` in 1: downstream accepts `tx_data` this cycle.

## Operation
- Decode: `addr[29]`=0 selects RAM at index `addr[log2(RAM_WORDS)-1:0]`; higher bits are ignored, so RAM aliases across the lower half. `addr[29]`=1 selects I/O at word offset `addr[1:0]`; `addr[28:2]` are ignored.
- RAM write: `we` writes `wdata` to the indexed word. RAM has no reset and is uninitialised.
- I/O offset 0, TXDATA: a write pushes `wdata[7:0]`; a read returns 0.
- I/O offset 1, STATUS, read-only:
  - bit0 = full, bit1 = empty, bit2 = sticky overflow.
  - bits[15:8] = occupancy count, zero-extended.
  - A read clears overflow at the sampling edge; the returned value shows overflow=1 if it was set.
- I/O offset 2, CYCLE: returns a 32-bit counter. The counter increments every cycle, wraps 0xFFFFFFFF→0, and writes to it are ignored.
- I/O offset 3: reads 0; writes are ignored.
- Push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle. Otherwise the byte is dropped and overflow is set.
- Pop occurs when `tx_valid && tx_ready`; the head advances.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- `tx_data` is undefined-but-stable when `tx_valid`=0; the bench must not check it then.
- `re`&&`we` on the same address: the write is performed and `rdata` returns the pre-write contents (read-before-write). The CPU never issues this; it is defined for robustness only.

## Timing
- Read latency 1: `re` high at edge N samples `addr`; `rdata` is valid from just after edge N until the next edge with `re` high.
- `rdata` holds its value on cycles with `re` low.
- CYCLE read returns the counter value before the increment of that same edge.
- Writes take effect at the edge where `we` is high.
- A pushed byte appears on `tx_data`/`tx_valid` one cycle later; there is no same-cycle bypass.
- STATUS reflects the FIFO state before the sampling edge's push/pop.
- Reset values: `rdata`=0, `tx_valid`=0, count=0, pointers=0, overflow=0, CYCLE=0.
- Reset asserted mid-operation discards FIFO contents. `tx_valid` drops asynchronously with `reset`. RAM is retained.

## Structure
- Shared package `bus_pkg`:
  - `IO_SEL_BIT`=29.
  - Offsets `OFF_TXDATA`=0, `OFF_STATUS`=1, `OFF_CYCLE`=2.
  - Status bit indices `ST_FULL`, `ST_EMPTY`, `ST_OVF`, and `ST_COUNT_LSB`=8.
- Submodule `byte_fifo`:
  - Parameterised depth.
  - Inputs `push`/`din`/`pop`; outputs `dout`/`full`/`empty`/`count`; async reset.
  - Owns the pointer/count logic.
- The top level holds the RAM array, decode, the `rdata` register, the cycle counter and the overflow flag.

## Test plan
- Write 0xDEADBEEF to addr 0x5, then `re` at addr 0x5 → `rdata`=0xDEADBEEF the cycle after. Read addr 0x405 (alias at RAM_WORDS=1024) → 0xDEADBEEF.
- Release reset, idle 10 cycles, read CYCLE → 0x0000000A ±0 per defined sampling. A second read 1 cycle later returns +1.
- With `tx_ready`=0, push bytes 0x41..0x49 (9 pushes):
  - 9th dropped.
  - STATUS read → 0x00000805 (count 8, full, overflow).
  - Immediate second read → 0x00000801.
- With `tx_ready`=1, push 0x55 → `tx_valid` high for one cycle with `tx_data`=0x55, then STATUS → 0x00000002.
- With the FIFO full and `tx_ready`=1, push 0x7A in the same cycle → accepted, no overflow, count stays 8, 0x7A emerges last.
- Assert `reset` mid-drain with 4 bytes queued → `tx_valid` low immediately. After release, STATUS=0x00000002; the previously written RAM word still reads back.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: shared constants for the CPU bus target.
//   IO_SEL_BIT      address bit that selects the I/O page over RAM
//   OFF_*           word offsets within the I/O page (addr[1:0])
//   ST_*            bit positions inside the STATUS word
//   make_status()   assembles the STATUS read value
package bus_pkg;

    localparam int IO_SEL_BIT = 29;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CYCLE  = 2'd2;

    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_COUNT_LSB = 8;

    function automatic logic [31:0] make_status(input logic       full,
                                                input logic       empty,
                                                input logic       ovf,
                                                input logic [7:0] count);
        logic [31:0] v;
        v                            = '0;
        v[ST_FULL]                   = full;
        v[ST_EMPTY]                  = empty;
        v[ST_OVF]                    = ovf;
        v[ST_COUNT_LSB +: 8]         = count;
        return v;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: byte-wide circular FIFO with occupancy count.
//   clk, rst        clock, async active-high reset (clears pointers/count)
//   push, din       write request and byte; accepted if not full or popping
//   pop             read request; ignored when empty
//   dout            head byte (stale storage when empty)
//   full, empty     occupancy flags
//   count           occupancy, 0..DEPTH
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_pop;
    logic          w_push;

    assign full   = (r_count == CW'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign dout   = r_mem[r_rd_ptr];

    assign w_pop  = pop && !empty;
    // A pop in the same cycle frees the slot being written, so a full FIFO
    // can still take a byte (wr_ptr == rd_ptr then, and the head is read
    // out at this same edge before being overwritten).
    assign w_push = push && (!full || w_pop);

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (w_pop && !w_push) r_count <= r_count - CW'(1);
        end
    end

endmodule

// File: rtl/bus_target.sv
// bus_target: zero-wait-state responder for the CPU word bus.
//   clk, reset      clock, async active-high reset (RAM contents retained)
//   addr, wdata     word address and write data
//   re, we          read / write strobes
//   rdata           registered read data, held while re is low
//   tx_data         TX FIFO head byte
//   tx_valid        TX FIFO non-empty
//   tx_ready        downstream accepts tx_data this cycle
// addr[29]=0 selects RAM (aliased), addr[29]=1 the I/O page at addr[1:0]:
// 0 TXDATA (write pushes), 1 STATUS, 2 CYCLE, 3 reserved.
module bus_target
    import bus_pkg::*;
#(
    parameter int RAM_WORDS  = 1024,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] addr,
    input  logic [31:0] wdata,
    input  logic        re,
    input  logic        we,
    output logic [31:0] rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]       r_ram [RAM_WORDS];
    logic [31:0]       r_rdata;
    logic [31:0]       r_cycle;
    logic              r_ovf;

    logic              w_io;
    logic [1:0]        w_off;
    logic [RAM_AW-1:0] w_ram_idx;
    logic              w_push_req;
    logic              w_pop;
    logic              w_drop;
    logic              w_status_rd;
    logic              w_full;
    logic              w_empty;
    logic [CW-1:0]     w_count;
    logic [31:0]       w_rd_val;
    logic              w_unused;

    assign w_io        = addr[IO_SEL_BIT];
    assign w_off       = addr[1:0];
    assign w_ram_idx   = addr[RAM_AW-1:0];
    assign w_unused    = &{1'b0, addr[28:2]};

    assign w_push_req  = we && w_io && (w_off == OFF_TXDATA);
    assign w_pop       = tx_valid && tx_ready;
    assign w_drop      = w_push_req && w_full && !w_pop;
    assign w_status_rd = re && w_io && (w_off == OFF_STATUS);

    assign tx_valid    = !w_empty;
    assign rdata       = r_rdata;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (w_push_req),
        .din   (wdata[7:0]),
        .pop   (w_pop),
        .dout  (tx_data),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // All sources are pre-edge values, so STATUS/CYCLE/RAM reads see the
    // state before this edge's push, pop, increment or write.
    always_comb begin
        w_rd_val = '0;
        if (!w_io) begin
            w_rd_val = r_ram[w_ram_idx];
        end else begin
            case (w_off)
                OFF_STATUS: w_rd_val = make_status(w_full, w_empty, r_ovf, 8'(w_count));
                OFF_CYCLE:  w_rd_val = r_cycle;
                default:    w_rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (we && !w_io) begin
            r_ram[w_ram_idx] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
            r_cycle <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (re) r_rdata <= w_rd_val;
            // A drop and a STATUS read cannot coincide (one address per cycle).
            if (w_drop)           r_ovf <= 1'b1;
            else if (w_status_rd) r_ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bus_target.sv
module tb_bus_target;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [29:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        re = 1'b0;
    logic        we = 1'b0;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [29:0] IO_TX  = 30'h2000_0000;
    localparam logic [29:0] IO_ST  = 30'h2000_0001;
    localparam logic [29:0] IO_CYC = 30'h2000_0002;
    localparam logic [29:0] IO_RSV = 30'h2000_0003;

    bus_target #(.RAM_WORDS(1024), .FIFO_DEPTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .wdata    (wdata),
        .re       (re),
        .we       (we),
        .rdata    (rdata),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        re = 1'b0;
        we = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        we = 1'b1; re = 1'b0; addr = IO_TX; wdata = {24'h0, b};
        cyc();
        we = 1'b0;
    endtask

    task automatic rd(input logic [29:0] a);
        re = 1'b1; we = 1'b0; addr = a;
        cyc();
        re = 1'b0;
    endtask

    initial begin
        // Reset state
        cyc();
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_tx_valid", {31'h0, tx_valid}, 32'h0);

        // Release between edges; 10 idle edges then CYCLE read samples 10
        reset = 1'b0;
        for (int i = 0; i < 10; i++) cyc();
        re = 1'b1; addr = IO_CYC;
        cyc();
        chk("cycle_first", rdata, 32'h0000_000A);
        cyc();
        chk("cycle_second", rdata, 32'h0000_000B);
        idle();

        // RAM write / read / alias / hold / reserved I/O
        we = 1'b1; addr = 30'h5; wdata = 32'hDEAD_BEEF;
        cyc();
        idle();
        rd(30'h5);
        chk("ram_read", rdata, 32'hDEAD_BEEF);
        rd(30'h405);
        chk("ram_alias", rdata, 32'hDEAD_BEEF);
        cyc();
        chk("rdata_hold", rdata, 32'hDEAD_BEEF);
        rd(IO_RSV);
        chk("io_rsv_read", rdata, 32'h0);
        rd(IO_TX);
        chk("txdata_read", rdata, 32'h0);

        // Fill with tx_ready=0, 9th byte dropped
        tx_ready = 1'b0;
        rd(IO_ST);
        chk("status_idle", rdata, 32'h0000_0002);
        for (int i = 0; i < 9; i++) begin
            push(8'h41 + 8'(i));
            if (i == 0) begin
                chk("first_valid", {31'h0, tx_valid}, 32'h1);
                chk("first_data", {24'h0, tx_data}, 32'h41);
            end
        end
        rd(IO_ST);
        chk("status_full_ovf", rdata, 32'h0000_0805);
        rd(IO_ST);
        chk("status_ovf_cleared", rdata, 32'h0000_0801);

        // Drain: 0x41..0x48, the dropped 0x49 must not appear
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_valid", {31'h0, tx_valid}, 32'h1);
            chk("drain_data", {24'h0, tx_data}, 32'h41 + i);
            cyc();
        end
        chk("drain_empty", {31'h0, tx_valid}, 32'h0);

        // Single byte through with tx_ready=1
        push(8'h55);
        chk("single_valid", {31'h0, tx_valid}, 32'h1);
        chk("single_data", {24'h0, tx_data}, 32'h55);
        cyc();
        chk("single_gone", {31'h0, tx_valid}, 32'h0);
        rd(IO_ST);
        chk("status_after_single", rdata, 32'h0000_0002);

        // Full FIFO, push and pop in the same cycle
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'h61 + 8'(i));
        tx_ready = 1'b1;
        push(8'h7A);
        tx_ready = 1'b0;
        rd(IO_ST);
        chk("status_push_pop_full", rdata, 32'h0000_0801);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("pp_valid", {31'h0, tx_valid}, 32'h1);
            chk("pp_data", {24'h0, tx_data}, (i == 7) ? 32'h7A : 32'h62 + i);
            cyc();
        end
        chk("pp_empty", {31'h0, tx_valid}, 32'h0);

        // Reset mid-drain
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
        tx_ready = 1'b1;
        cyc();
        chk("pre_reset_valid", {31'h0, tx_valid}, 32'h1);
        reset = 1'b1;
        #1;
        chk("reset_async_valid", {31'h0, tx_valid}, 32'h0);
        chk("reset_async_rdata", rdata, 32'h0);
        cyc();
        cyc();
        reset = 1'b0;
        tx_ready = 1'b0;
        rd(IO_ST);
        chk("status_after_reset", rdata, 32'h0000_0002);
        rd(30'h5);
        chk("ram_retained", rdata, 32'hDEAD_BEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
